// File: rtl/serial_frame_buffer_pkg.sv
// Shared types and helpers for the multi-lane serial frame buffer.
// The PARITY state exists only when FRAME_PARITY_EN is defined.
package serial_frame_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef FRAME_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } sfb_state_t;

    // Counter width for a count of 'value' states; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/serial_frame_lane.sv
// One serial lane: holding register, shift register with selectable bit order,
// and (with FRAME_PARITY_EN) an even-parity bit captured at frame start.
module serial_frame_lane
    import serial_frame_buffer_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_en,
    input  logic             start,
    input  logic             shift,
`ifdef FRAME_PARITY_EN
    input  logic             par_sel,
`endif
    output logic             bit_out
);

    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] frame_word;
    logic             data_bit;

    // A load in the same cycle as start must transmit the newly loaded word.
    assign frame_word = load_en ? data : hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (load_en) begin
            hold_q <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (start) begin
            shreg_q <= frame_word;
        end else if (shift) begin
            shreg_q <= (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
        end
    end

    assign data_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

`ifdef FRAME_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (start) begin
            parity_q <= ^frame_word;
        end
    end

    assign bit_out = par_sel ? parity_q : data_bit;
`else
    assign bit_out = data_bit;
`endif

endmodule

// File: rtl/serial_frame_buffer.sv
// Multi-channel parallel-to-serial frame buffer: FSM, slot/bit counters and status.
// Define FRAME_PARITY_EN to append one even-parity bit per lane after the data bits.
module serial_frame_buffer
    import serial_frame_buffer_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int CHANNELS   = 2,
    parameter int BIT_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      send,
    output logic                      ready,
    output logic                      busy,
    output logic                      bit_valid,
    output logic                      bit_start,
    output logic [CHANNELS-1:0]       bits_out,
    output logic                      done
);

    localparam int SW = clog2_min1(BIT_CYCLES);
    localparam int BW = clog2_min1(WIDTH);
    localparam logic [SW-1:0] SLOT_LAST = SW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    sfb_state_t          state_q;
    sfb_state_t          state_d;
    logic [SW-1:0]       slot_q;
    logic [BW-1:0]       bit_q;
    logic                load_en;
    logic                start;
    logic                shift;
    logic                active;
    logic                last_slot;
    logic                last_bit;
    logic [CHANNELS-1:0] lane_bit;

    assign load_en   = (state_q == ST_IDLE) && load;
    assign last_slot = (slot_q == SLOT_LAST);
    assign last_bit  = (bit_q == BIT_LAST);
`ifdef FRAME_PARITY_EN
    assign active    = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
`else
    assign active    = (state_q == ST_SHIFT);
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_slot) begin
                    shift = 1'b1;
                    if (last_bit) begin
`ifdef FRAME_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef FRAME_PARITY_EN
            ST_PARITY: begin
                if (last_slot) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot counter paces each bit; bit counter advances only on a slot wrap in SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            bit_q  <= '0;
        end else if (active) begin
            slot_q <= last_slot ? '0 : slot_q + 1'b1;
            if ((state_q == ST_SHIFT) && last_slot) begin
                bit_q <= last_bit ? '0 : bit_q + 1'b1;
            end
        end else begin
            slot_q <= '0;
            bit_q  <= '0;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        serial_frame_lane #(
            .WIDTH     (WIDTH),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .data    (data_in[c*WIDTH +: WIDTH]),
            .load_en (load_en),
            .start   (start),
            .shift   (shift),
`ifdef FRAME_PARITY_EN
            .par_sel (state_q == ST_PARITY),
`endif
            .bit_out (lane_bit[c])
        );
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign bit_valid = active;
    assign bit_start = active && (slot_q == '0);
    assign done      = (state_q == ST_DONE);
    assign bits_out  = active ? lane_bit : '0;

endmodule

// File: tb/tb_serial_frame_buffer.sv
// Bench for serial_frame_buffer: three instances (BIT_CYCLES 1 and 3, LSB-first)
// checked cycle by cycle against a word-level model; honours FRAME_PARITY_EN.
module tb_serial_frame_buffer;

    localparam int W  = 8;
    localparam int NI = 3;
`ifdef FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load_i  [NI];
    logic        send_i  [NI];
    logic [15:0] data_i  [NI];
    logic        ready_o [NI];
    logic        busy_o  [NI];
    logic        valid_o [NI];
    logic        start_o [NI];
    logic        done_o  [NI];
    logic [1:0]  bits_o  [NI];

    logic [7:0]  model_hold [NI][2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    serial_frame_buffer #(.WIDTH(W), .CHANNELS(2), .BIT_CYCLES(1), .MSB_FIRST(1)) u_bc1 (
        .clk(clk), .rst(rst), .load(load_i[0]), .data_in(data_i[0]), .send(send_i[0]),
        .ready(ready_o[0]), .busy(busy_o[0]), .bit_valid(valid_o[0]), .bit_start(start_o[0]),
        .bits_out(bits_o[0]), .done(done_o[0]));

    serial_frame_buffer #(.WIDTH(W), .CHANNELS(2), .BIT_CYCLES(3), .MSB_FIRST(1)) u_bc3 (
        .clk(clk), .rst(rst), .load(load_i[1]), .data_in(data_i[1]), .send(send_i[1]),
        .ready(ready_o[1]), .busy(busy_o[1]), .bit_valid(valid_o[1]), .bit_start(start_o[1]),
        .bits_out(bits_o[1]), .done(done_o[1]));

    serial_frame_buffer #(.WIDTH(W), .CHANNELS(2), .BIT_CYCLES(1), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .load(load_i[2]), .data_in(data_i[2]), .send(send_i[2]),
        .ready(ready_o[2]), .busy(busy_o[2]), .bit_valid(valid_o[2]), .bit_start(start_o[2]),
        .bits_out(bits_o[2]), .done(done_o[2]));

    function automatic int bc_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int d);
        return (d != 2);
    endfunction

    // Bit 'idx' of a frame as seen on the wire; index W is the even-parity bit.
    function automatic logic exp_bit(input logic [7:0] word, input int idx, input bit msb);
        if (idx >= W) return ^word;
        return msb ? word[W-1-idx] : word[idx];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkIdle(input int d, input string tag);
        checkOutput($sformatf("%s d%0d ready", tag, d), 32'(ready_o[d]), 32'd1);
        checkOutput($sformatf("%s d%0d busy", tag, d), 32'(busy_o[d]), 32'd0);
        checkOutput($sformatf("%s d%0d bit_valid", tag, d), 32'(valid_o[d]), 32'd0);
        checkOutput($sformatf("%s d%0d bit_start", tag, d), 32'(start_o[d]), 32'd0);
        checkOutput($sformatf("%s d%0d bits_out", tag, d), 32'(bits_o[d]), 32'd0);
        checkOutput($sformatf("%s d%0d done", tag, d), 32'(done_o[d]), 32'd0);
    endtask

    task automatic applyStimulus(input int d, input logic ld, input logic sd, input logic [15:0] dat);
        load_i[d] = ld;
        send_i[d] = sd;
        data_i[d] = dat;
    endtask

    // Runs one frame on instance d; disturb drives an ignored load+send mid-frame,
    // abort_at >= 0 asserts reset while that cycle of the frame is on the wire.
    task automatic runFrame(input int d, input logic [15:0] dat, input bit do_load,
                            input bit disturb, input int abort_at);
        int         b;
        int         f;
        logic [1:0] exp_bits;
        b = bc_of(d);
        f = (W + PAR) * b;
        @(negedge clk);
        applyStimulus(d, do_load, 1'b1, dat);
        if (do_load) begin
            model_hold[d][0] = dat[7:0];
            model_hold[d][1] = dat[15:8];
        end
        @(negedge clk);
        applyStimulus(d, 1'b0, 1'b0, dat);
        for (int t = 0; t < f; t++) begin
            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                for (int k = 0; k < NI; k++) checkIdle(k, "abort");
                for (int k = 0; k < NI; k++) begin
                    model_hold[k][0] = 8'h00;
                    model_hold[k][1] = 8'h00;
                end
                @(posedge clk);
                #1;
                checkOutput("abort no done", 32'(done_o[d]), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            for (int c = 0; c < 2; c++) exp_bits[c] = exp_bit(model_hold[d][c], t / b, msb_of(d));
            checkOutput($sformatf("d%0d t%0d bit_valid", d, t), 32'(valid_o[d]), 32'd1);
            checkOutput($sformatf("d%0d t%0d bit_start", d, t), 32'(start_o[d]), 32'((t % b) == 0));
            checkOutput($sformatf("d%0d t%0d bits_out", d, t), 32'(bits_o[d]), 32'(exp_bits));
            checkOutput($sformatf("d%0d t%0d busy", d, t), 32'(busy_o[d]), 32'd1);
            checkOutput($sformatf("d%0d t%0d ready", d, t), 32'(ready_o[d]), 32'd0);
            checkOutput($sformatf("d%0d t%0d done", d, t), 32'(done_o[d]), 32'd0);
            if (disturb && t == 2) applyStimulus(d, 1'b1, 1'b1, 16'h1111);
            else applyStimulus(d, 1'b0, 1'b0, dat);
            @(negedge clk);
        end
        applyStimulus(d, 1'b0, 1'b0, dat);
        checkOutput($sformatf("d%0d F done", d), 32'(done_o[d]), 32'd1);
        checkOutput($sformatf("d%0d F busy", d), 32'(busy_o[d]), 32'd1);
        checkOutput($sformatf("d%0d F ready", d), 32'(ready_o[d]), 32'd0);
        checkOutput($sformatf("d%0d F bit_valid", d), 32'(valid_o[d]), 32'd0);
        checkOutput($sformatf("d%0d F bits_out", d), 32'(bits_o[d]), 32'd0);
        @(negedge clk);
        checkIdle(d, "post");
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < NI; d++) begin
            applyStimulus(d, 1'b0, 1'b0, 16'h0000);
            model_hold[d][0] = 8'h00;
            model_hold[d][1] = 8'h00;
        end
        #12;
        for (int d = 0; d < NI; d++) checkIdle(d, "reset");
        @(negedge clk);
        rst = 1'b0;

        runFrame(0, {8'h3C, 8'hA5}, 1'b1, 1'b0, -1);
        runFrame(1, {8'h3C, 8'hA5}, 1'b1, 1'b0, -1);
        runFrame(0, {8'h07, 8'hA5}, 1'b1, 1'b0, -1);
        runFrame(0, {8'h00, 8'hFF}, 1'b1, 1'b1, -1);
        runFrame(0, 16'h5A5A, 1'b0, 1'b0, -1);
        runFrame(0, 16'(~$urandom), 1'b1, 1'b0, 4);
        runFrame(0, 16'hFFFF, 1'b0, 1'b0, -1);
        runFrame(2, {8'h00, 8'h01}, 1'b1, 1'b0, -1);

        for (int i = 0; i < 9; i++) begin
            runFrame(i % NI, 16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
